// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider with period tick and load/ack handshake.
// Define CLKDIV_DUTY_EN to add a programmable high time (duty_in) captured with each load.
module clk_div_prog #(
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 100_000
) (
    input  logic             incoming_CLK100MHZ,
    input  logic             incoming_RST_N,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
`ifdef CLKDIV_DUTY_EN
    input  logic [WIDTH-1:0] duty_in,
`endif
    input  logic             load,
    output logic             load_ack,
    output logic             busy,
    output logic             outgoing_CLK,
    output logic             tick
);
    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV >> 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] r_ctr, r_n, r_h, r_pend_div;
    logic             r_pending, r_out, r_tick, r_ack;
    logic [WIDTH-1:0] w_div_clamped, w_new_h;
    logic             w_last, w_apply;

    assign w_div_clamped = (div_in < TWO) ? TWO : div_in;
    assign w_last        = (r_ctr == r_n - ONE);
    // A pending load lands at a period boundary, or at once while stopped.
    assign w_apply       = r_pending & (w_last | ~enable);

`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] r_pend_h, w_duty_clamped;
    // High time is clamped against the new period so the output always toggles.
    assign w_duty_clamped = (duty_in == '0) ? ONE :
                            (duty_in >= w_div_clamped) ? w_div_clamped - ONE : duty_in;
    assign w_new_h = r_pend_h;
    always_ff @(posedge incoming_CLK100MHZ or negedge incoming_RST_N) begin
        if (!incoming_RST_N)
            r_pend_h <= DEF_H;
        else if (load)
            r_pend_h <= w_duty_clamped;
    end
`else
    assign w_new_h = r_pend_div >> 1;
`endif

    always_ff @(posedge incoming_CLK100MHZ or negedge incoming_RST_N) begin
        if (!incoming_RST_N) begin
            r_ctr      <= '0;
            r_n        <= DEF_N;
            r_h        <= DEF_H;
            r_pend_div <= DEF_N;
            r_pending  <= 1'b0;
            r_out      <= 1'b0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            if (enable) begin
                r_ctr  <= w_last ? '0 : r_ctr + ONE;
                r_out  <= (r_ctr < r_h);
                r_tick <= w_last;
            end else begin
                r_ctr  <= '0;
                r_out  <= 1'b0;
                r_tick <= 1'b0;
            end
            if (w_apply) begin
                r_n <= r_pend_div;
                r_h <= w_new_h;
            end
            if (load)
                r_pend_div <= w_div_clamped;
            r_pending <= load | (r_pending & ~w_apply);
            r_ack     <= w_apply;
        end
    end

    assign outgoing_CLK = r_out;
    assign tick         = r_tick;
    assign load_ack     = r_ack;
    assign busy         = r_pending;
endmodule
